change_dispenser: RTL and testbench
===================================

Name: change_dispenser

Overview:
- Downstream consumer of the vending FSM's change amount.
- Converts one change request into a timed sequence of single-coin eject pulses to three coin hoppers, using a greedy largest-coin-first algorithm.
- Skips denominations whose hopper reports empty.
- Raises a sticky fault if the remaining change cannot be paid out.
- Runs on the divided system clock, alongside the vending FSM.

Parameters:
- AMT_W, 8, width of the change amount and remaining counter (credit units).
- VAL_HI, 5, credit value of the high coin (hopper 2).
- VAL_MID, 2, credit value of the mid coin (hopper 1).
- VAL_LO, 1, credit value of the low coin (hopper 0).
- PULSE_CYCLES, 2, cycles each eject pulse is held; must be >=1.
- GAP_CYCLES, 1, idle cycles after each pulse; must be >=1.
- Constraint: VAL_HI > VAL_MID > VAL_LO >= 1.

Ports:
- clk  in  1  system clock (divided clock at top level).
- reset  in  1  synchronous, active-high reset.
- change_valid  in  1  request strobe; accepted only when ready=1.
- change_amount  in  AMT_W  credit units to return; sampled on acceptance.
- hopper_empty  in  3  per-hopper empty flag; [2]=HI, [1]=MID, [0]=LO.
- fault_clr  in  1  clears FAULT state.
- ready  out  1  high in IDLE only.
- busy  out  1  high in SELECT/PULSE/GAP.
- coin_out  out  3  one-hot eject pulse, bit mapping as hopper_empty.
- done  out  1  one-cycle pulse on successful completion.
- fault  out  1  high while in FAULT.
- remaining  out  AMT_W  change still owed.
- coin_count  out  8  coins ejected in the current transaction; saturates at 255.

Behaviour:
- Reset: synchronous, active-high, and takes effect at any state, including mid-pulse.
  - At the next edge: state=IDLE, ready=1, busy=0, coin_out=0, done=0, fault=0, remaining=0, coin_count=0.
- All outputs are registered.
- States: IDLE, SELECT, PULSE, GAP, DONE, FAULT.
- IDLE:
  - On change_valid at edge E0: latch remaining=change_amount and clear coin_count.
  - Next state is SELECT, or DONE if change_amount==0.
  - change_valid is ignored in every state other than IDLE.
- SELECT (one cycle):
  - Evaluate in priority order HI, MID, LO.
  - Pick the first denomination with value <= remaining and hopper_empty bit == 0.
  - hopper_empty is sampled only in SELECT.
  - If a coin is picked: next state PULSE, coin_out = its one-hot bit, remaining -= value, coin_count += 1 (saturating), timer = PULSE_CYCLES-1.
  - If none is eligible: next state FAULT; remaining holds the unpaid amount.
- PULSE:
  - coin_out is held.
  - When timer==0: next state GAP, coin_out=0, timer=GAP_CYCLES-1.
  - Otherwise timer decrements.
- GAP:
  - When timer==0: next state DONE if remaining==0, else SELECT.
  - Otherwise timer decrements.
- DONE: done=1 for exactly one cycle, then IDLE. remaining is 0.
- FAULT:
  - fault=1, busy=0, ready=0.
  - Stays in FAULT until fault_clr=1, then next state IDLE with remaining=0.
  - fault_clr is ignored in all other states.
- Per-coin cost: 1 + PULSE_CYCLES + GAP_CYCLES cycles. No two coin_out bits are ever high together.
- Arithmetic:
  - The remaining subtraction never underflows, because selection guarantees value <= remaining.
  - Compare widths are zero-extended to AMT_W.

Test Plan:
- Greedy payout, defaults, hoppers full, amount=8 accepted at E0:
  - coin_out=100 after E1–E2, 010 after E5–E6, 001 after E9–E10.
  - done=1 only between E12 and E13; ready=1 after E13; coin_count=3.
- Zero amount: amount=0 at E0 -> done=1 after E0, ready=1 after E1, coin_out never asserted.
- HI hopper empty (hopper_empty=100), amount=7 -> coins MID, MID, MID, LO in that order; done=1; coin_count=4.
- Unpayable remainder: hopper_empty=001, amount=3:
  - One MID pulse, then FAULT with fault=1 and remaining=1.
  - fault_clr=1 -> IDLE, remaining=0, fault=0.
- Ignored request while busy: change_valid with amount=9 during PULSE -> no effect; the original sequence completes unchanged.
- Reset mid-operation: reset=1 during the second PULSE cycle of amount=8 -> after that edge, coin_out=0, remaining=0, ready=1.
  - A new request of 2 afterwards yields exactly one MID pulse.

Source files
------------

// File: rtl/change_dispenser.sv
// Turns one change request into a timed series of single-coin eject pulses.
// Coins are chosen largest first, and any hopper that reports empty is skipped.
module change_dispenser #(
    parameter int AMT_W        = 8,
    parameter int VAL_HI       = 5,
    parameter int VAL_MID      = 2,
    parameter int VAL_LO       = 1,
    parameter int PULSE_CYCLES = 2,
    parameter int GAP_CYCLES   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             change_valid,
    input  logic [AMT_W-1:0] change_amount,
    input  logic [2:0]       hopper_empty,
    input  logic             fault_clr,
    output logic             ready,
    output logic             busy,
    output logic [2:0]       coin_out,
    output logic             done,
    output logic             fault,
    output logic [AMT_W-1:0] remaining,
    output logic [7:0]       coin_count
);
    localparam int TMR_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [AMT_W-1:0] HI_V  = AMT_W'(VAL_HI);
    localparam logic [AMT_W-1:0] MID_V = AMT_W'(VAL_MID);
    localparam logic [AMT_W-1:0] LO_V  = AMT_W'(VAL_LO);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SELECT = 3'd1;
    localparam logic [2:0] S_PULSE  = 3'd2;
    localparam logic [2:0] S_GAP    = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam logic [2:0] S_FAULT  = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [2:0]       coin_q, coin_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             ready_q, busy_q, done_q, fault_q;

    logic [2:0]       pick;
    logic [AMT_W-1:0] pick_val;

    // Greedy selection: the highest denomination that still fits and is stocked
    always_comb begin
        pick     = 3'b000;
        pick_val = '0;
        if (!hopper_empty[2] && rem_q >= HI_V) begin
            pick     = 3'b100;
            pick_val = HI_V;
        end else if (!hopper_empty[1] && rem_q >= MID_V) begin
            pick     = 3'b010;
            pick_val = MID_V;
        end else if (!hopper_empty[0] && rem_q >= LO_V) begin
            pick     = 3'b001;
            pick_val = LO_V;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        coin_d  = coin_q;
        tmr_d   = tmr_q;
        case (state_q)
            S_IDLE: begin
                if (change_valid) begin
                    rem_d   = change_amount;
                    cnt_d   = '0;
                    state_d = (change_amount == '0) ? S_DONE : S_SELECT;
                end
            end
            S_SELECT: begin
                if (pick != 3'b000) begin
                    state_d = S_PULSE;
                    coin_d  = pick;
                    rem_d   = rem_q - pick_val;
                    cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                    tmr_d   = TMR_W'(PULSE_CYCLES - 1);
                end else begin
                    state_d = S_FAULT;
                end
            end
            S_PULSE: begin
                if (tmr_q == '0) begin
                    state_d = S_GAP;
                    coin_d  = 3'b000;
                    tmr_d   = TMR_W'(GAP_CYCLES - 1);
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            S_GAP: begin
                if (tmr_q == '0) state_d = (rem_q == '0) ? S_DONE : S_SELECT;
                else             tmr_d   = tmr_q - 1'b1;
            end
            S_DONE: state_d = S_IDLE;
            S_FAULT: begin
                if (fault_clr) begin
                    state_d = S_IDLE;
                    rem_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Status flags are decoded from the next state so that every output comes straight from a flop
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            cnt_q   <= '0;
            coin_q  <= 3'b000;
            tmr_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            coin_q  <= coin_d;
            tmr_q   <= tmr_d;
            ready_q <= (state_d == S_IDLE);
            busy_q  <= (state_d == S_SELECT) || (state_d == S_PULSE) || (state_d == S_GAP);
            done_q  <= (state_d == S_DONE);
            fault_q <= (state_d == S_FAULT);
        end
    end

    assign ready      = ready_q;
    assign busy       = busy_q;
    assign coin_out   = coin_q;
    assign done       = done_q;
    assign fault      = fault_q;
    assign remaining  = rem_q;
    assign coin_count = cnt_q;
endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: a cycle-timing reference model checked on every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_change_dispenser;
    localparam int P = 2;
    localparam int G = 1;
    localparam int C = 1 + P + G;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       change_valid = 1'b0;
    logic [7:0] change_amount = '0;
    logic [2:0] hopper_empty = '0;
    logic       fault_clr = 1'b0;
    logic       ready, busy, done, fault;
    logic [2:0] coin_out;
    logic [7:0] remaining, coin_count;

    int checks = 0;
    int errors = 0;
    bit chk_on = 0;

    change_dispenser dut (
        .clk(clk), .reset(reset), .change_valid(change_valid), .change_amount(change_amount),
        .hopper_empty(hopper_empty), .fault_clr(fault_clr), .ready(ready), .busy(busy),
        .coin_out(coin_out), .done(done), .fault(fault), .remaining(remaining),
        .coin_count(coin_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // The reference model works from the elapsed time t since the request was accepted.
    // Coin k is selected at edge 1+k*C, its pulse ends P edges later, and the
    // decision to finish or pick again falls on the last gap edge.
    bit         m_act, m_done, m_fault;
    int         t;
    logic [7:0] m_rem;
    int         m_cnt;
    logic [2:0] m_coin;

    function automatic logic [2:0] greedy(input logic [7:0] rem, input logic [2:0] he);
        if (!he[2] && rem >= 5) return 3'b100;
        if (!he[1] && rem >= 2) return 3'b010;
        if (!he[0] && rem >= 1) return 3'b001;
        return 3'b000;
    endfunction

    function automatic int coin_val(input logic [2:0] c);
        return c[2] ? 5 : c[1] ? 2 : c[0] ? 1 : 0;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_act = 0; m_done = 0; m_fault = 0; m_rem = 0; m_cnt = 0; m_coin = 0; t = 0;
        end else if (m_fault) begin
            if (fault_clr) begin m_fault = 0; m_rem = 0; end
        end else if (m_done) begin
            m_done = 0;
        end else if (!m_act) begin
            if (change_valid) begin
                m_rem = change_amount;
                m_cnt = 0;
                if (change_amount == 0) m_done = 1;
                else begin m_act = 1; t = 0; end
            end
        end else begin
            int p;
            logic [2:0] c;
            t++;
            p = (t - 1) % C;
            if (p == 0) begin
                c = greedy(m_rem, hopper_empty);
                if (c == 0) begin m_act = 0; m_fault = 1; end
                else begin
                    m_coin = c;
                    m_rem  = m_rem - 8'(coin_val(c));
                    m_cnt  = (m_cnt < 255) ? m_cnt + 1 : 255;
                end
            end else if (p == P) begin
                m_coin = 0;
            end else if (p == C - 1 && m_rem == 0) begin
                m_act = 0; m_done = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("ready", 32'(ready), 32'(!m_act && !m_done && !m_fault));
            chk("busy", 32'(busy), 32'(m_act));
            chk("coin_out", 32'(coin_out), 32'(m_coin));
            chk("done", 32'(done), 32'(m_done));
            chk("fault", 32'(fault), 32'(m_fault));
            chk("remaining", 32'(remaining), 32'(m_rem));
            chk("coin_count", 32'(coin_count), 32'(m_cnt));
        end
    end

    // Each new pulse is appended to seqcode as one hex digit, giving an ordered coin trace
    logic [31:0] seqcode = '0;
    logic [2:0]  prev_coin = '0;
    always @(negedge clk) begin
        if (coin_out != 0 && prev_coin == 0) seqcode = (seqcode << 4) | 32'(coin_out);
        prev_coin = coin_out;
    end

    task automatic req(input logic [7:0] amt);
        seqcode = 0;
        @(negedge clk);
        change_valid = 1; change_amount = amt;
        @(negedge clk);
        change_valid = 0;
    endtask

    task automatic wait_end(output int n);
        n = 0;
        while (!done && !fault && n < 300) begin @(negedge clk); n++; end
        if (n >= 300) chk("timeout", 32'(n), 32'(0));
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        reset = 0;
        chk_on = 1;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_remaining", 32'(remaining), 32'd0);
        chk("rst_coin_out", 32'(coin_out), 32'd0);

        req(8'd8);
        wait_end(n);
        chk("amt8_done_cycle", 32'(n), 32'd12);
        chk("amt8_seq", seqcode, 32'h421);
        chk("amt8_count", 32'(coin_count), 32'd3);
        @(negedge clk);
        chk("amt8_ready_after", 32'(ready), 32'd1);

        req(8'd0);
        wait_end(n);
        chk("zero_done_cycle", 32'(n), 32'd0);
        @(negedge clk);
        chk("zero_ready", 32'(ready), 32'd1);
        chk("zero_no_coin", seqcode, 32'h0);

        hopper_empty = 3'b100;
        req(8'd7);
        wait_end(n);
        chk("hi_empty_seq", seqcode, 32'h2221);
        chk("hi_empty_count", 32'(coin_count), 32'd4);
        chk("hi_empty_done", 32'(done), 32'd1);
        @(negedge clk);

        hopper_empty = 3'b001;
        req(8'd3);
        wait_end(n);
        chk("fault_flag", 32'(fault), 32'd1);
        chk("fault_rem", 32'(remaining), 32'd1);
        chk("fault_seq", seqcode, 32'h2);
        repeat (3) @(negedge clk);
        fault_clr = 1;
        @(negedge clk);
        fault_clr = 0;
        chk("clr_fault", 32'(fault), 32'd0);
        chk("clr_rem", 32'(remaining), 32'd0);
        chk("clr_ready", 32'(ready), 32'd1);
        hopper_empty = 3'b000;

        req(8'd8);
        @(negedge clk);
        change_valid = 1; change_amount = 8'd9;
        @(negedge clk);
        change_valid = 0;
        wait_end(n);
        chk("ignore_seq", seqcode, 32'h421);
        chk("ignore_count", 32'(coin_count), 32'd3);
        @(negedge clk);

        req(8'd8);
        @(negedge clk);
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        chk("midrst_coin", 32'(coin_out), 32'd0);
        chk("midrst_rem", 32'(remaining), 32'd0);
        chk("midrst_ready", 32'(ready), 32'd1);
        req(8'd2);
        wait_end(n);
        chk("midrst_seq", seqcode, 32'h2);
        @(negedge clk);

        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            change_valid  = ($urandom % 4) == 0;
            change_amount = 8'($urandom % 40);
            hopper_empty  = (($urandom % 4) == 0) ? 3'($urandom % 8) : 3'b000;
            fault_clr     = ($urandom % 6) == 0;
            reset         = ($urandom % 300) == 0;
        end
        @(negedge clk);
        reset = 0; change_valid = 0; fault_clr = 0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
